// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies,
// the busy-op predicate and the sequencer state type.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam int MDU_MULT_LAT_DEFAULT = 5;
  localparam int MDU_DIV_LAT_DEFAULT  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_mdu_busy_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/div datapath returning {hiNext, loNext} for the given op.
// A single unsigned divider on operand magnitudes serves both div and divu.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic        divSigned;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] qMag;
  logic [31:0] rMag;
  logic [31:0] qRes;
  logic [31:0] rRes;

  // Negating 0x80000000 leaves 0x80000000, which as an unsigned magnitude is
  // exactly 2^31, so the div overflow case falls out as lo=0x80000000, hi=0.
  always_comb begin
    prodS     = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prodU     = {32'b0, a_i} * {32'b0, b_i};
    divSigned = (op_i == MDU_DIV);
    absA      = (divSigned && a_i[31]) ? -a_i : a_i;
    absB      = (divSigned && b_i[31]) ? -b_i : b_i;
    qMag      = '0;
    rMag      = '0;
    if (b_i != 32'd0) begin
      qMag = absA / absB;
      rMag = absA % absB;
    end
    qRes = (divSigned && (a_i[31] ^ b_i[31])) ? -qMag : qMag;
    rRes = (divSigned && a_i[31]) ? -rMag : rMag;

    result_o = '0;
    case (op_i)
      MDU_MULT:  result_o = prodS;
      MDU_MULTU: result_o = prodU;
      MDU_DIV, MDU_DIVU: begin
        if (b_i == 32'd0) result_o = {a_i, 32'hFFFF_FFFF};
        else              result_o = {rRes, qRes};
      end
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Ex-stage multiply/divide unit: owns HI/LO, sequences multi-cycle mult/div
// through shadow registers and a countdown, and raises stall requests.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mduOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        stallReq,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mduRd
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lat_d;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      shHi_q;
  logic [31:0]      shLo_q;
  logic [63:0]      calcResult;

  mdu_calc u_calc (
    .op_i    (mduOp),
    .a_i     (srcA),
    .b_i     (srcB),
    .result_o(calcResult)
  );

  assign cnt_d = cnt_q - CNT_W'(1);
  assign lat_d = ((mduOp == MDU_DIV) || (mduOp == MDU_DIVU)) ? CNT_W'(DIV_LAT)
                                                             : CNT_W'(MULT_LAT);

  // Result is captured at accept; HI/LO only change on the edge the count hits zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shHi_q  <= '0;
      shLo_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_mdu_busy_op(mduOp)) begin
              shHi_q  <= calcResult[63:32];
              shLo_q  <= calcResult[31:0];
              cnt_q   <= lat_d;
              state_q <= ST_BUSY;
            end else if (mduOp == MDU_MTHI) begin
              hi_q <= srcA;
            end else if (mduOp == MDU_MTLO) begin
              lo_q <= srcA;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            hi_q    <= shHi_q;
            lo_q    <= shLo_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign stallReq = busy || (start && is_mdu_busy_op(mduOp));
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign mduRd    = (mduOp == MDU_MFHI) ? hi_q :
                    (mduOp == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed test-plan scenarios plus randomized
// traffic, all compared every cycle against an arithmetic reference model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mduOp = MDU_NONE;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy;
  logic        stallReq;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mduRd;

  int totalChecks = 0;
  int badChecks   = 0;
  bit checking    = 1'b0;

  mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mduOp   (mduOp),
    .srcA    (srcA),
    .srcB    (srcB),
    .busy    (busy),
    .stallReq(stallReq),
    .hi      (hi),
    .lo      (lo),
    .mduRd   (mduRd)
  );

  always #5 clk = ~clk;

  // Every comparison funnels through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural reference: what HI/LO must hold after each op, from plain 64-bit arithmetic.
  function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    res = '0;
    case (op)
      MDU_MULT:  res = sa * sb;
      MDU_MULTU: res = {32'b0, a} * {32'b0, b};
      MDU_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      MDU_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model state: committed HI/LO plus one outstanding result due at a known edge.
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [63:0] mPend = '0;
  logic        mPending = 1'b0;
  int          cycleNo = 0;
  int          doneEdge = 0;
  int          illegalStarts = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mHi      <= '0;
      mLo      <= '0;
      mPending <= 1'b0;
      cycleNo  <= 0;
    end else begin
      cycleNo <= cycleNo + 1;
      if (start && mPending) illegalStarts <= illegalStarts + 1;
      if (mPending) begin
        if (cycleNo == doneEdge) begin
          mHi      <= mPend[63:32];
          mLo      <= mPend[31:0];
          mPending <= 1'b0;
        end
      end else if (start) begin
        if (is_mdu_busy_op(mduOp)) begin
          mPend    <= refResult(mduOp, srcA, srcB);
          mPending <= 1'b1;
          doneEdge <= cycleNo + (((mduOp == MDU_DIV) || (mduOp == MDU_DIVU)) ? DIV_LAT : MULT_LAT);
        end else if (mduOp == MDU_MTHI) begin
          mHi <= srcA;
        end else if (mduOp == MDU_MTLO) begin
          mLo <= srcA;
        end
      end
    end
  end

  function automatic logic [31:0] expRd();
    if (mduOp == MDU_MFHI) return mHi;
    if (mduOp == MDU_MFLO) return mLo;
    return 32'd0;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("busy", 64'(busy), 64'(mPending));
      checkOutput("stallReq", 64'(stallReq),
                  64'(mPending || (start && is_mdu_busy_op(mduOp))));
      checkOutput("hi", 64'(hi), 64'(mHi));
      checkOutput("lo", 64'(lo), 64'(mLo));
      checkOutput("mduRd", 64'(mduRd), 64'(expRd()));
    end
  end

  task automatic applyStimulus(input logic st, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    start = st;
    mduOp = op;
    srcA  = a;
    srcB  = b;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Issue one op, then count cycles with busy high; returns at the first idle negedge.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busyCycles);
    nextCycle();
    applyStimulus(1'b1, op, a, b);
    busyCycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      busyCycles++;
      #1;
      applyStimulus(1'b0, MDU_NONE, '0, '0);
    end
    applyStimulus(1'b0, MDU_NONE, '0, '0);
  endtask

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;

    checkOutput("pin_mult", refResult(MDU_MULT, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    checkOutput("pin_multu", refResult(MDU_MULTU, 32'hFFFF_FFFE, 32'd3), 64'h0000_0002_FFFF_FFFA);
    checkOutput("pin_div", refResult(MDU_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("pin_divu0", refResult(MDU_DIVU, 32'd7, 32'd0), 64'h0000_0007_FFFF_FFFF);
    checkOutput("pin_divovf", refResult(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    reset    = 1'b0;
    checking = 1'b1;

    runOp(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n);
    checkOutput("mult_busy_cycles", 64'(n), 64'(MULT_LAT));
    checkOutput("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    runOp(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, n);
    checkOutput("multu_hi", 64'(hi), 64'h0000_0002);
    checkOutput("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    runOp(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
    checkOutput("div_busy_cycles", 64'(n), 64'(DIV_LAT));
    checkOutput("div_lo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("div_hi", 64'(hi), 64'hFFFF_FFFF);

    runOp(MDU_DIVU, 32'd7, 32'd0, n);
    checkOutput("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    checkOutput("divu0_hi", 64'(hi), 64'h0000_0007);

    runOp(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    #1;
    applyStimulus(1'b1, MDU_MFLO, '0, '0);
    #1;
    checkOutput("ovf_mflo", 64'(mduRd), 64'h8000_0000);
    checkOutput("ovf_hi", 64'(hi), 64'h0);

    nextCycle();
    applyStimulus(1'b1, MDU_MTHI, 32'h1234_5678, '0);
    #1;
    checkOutput("mthi_stall", 64'(stallReq), 64'd0);
    @(negedge clk);
    checkOutput("mthi_hi", 64'(hi), 64'h1234_5678);
    checkOutput("mthi_busy", 64'(busy), 64'd0);
    #1;
    applyStimulus(1'b1, MDU_MFHI, '0, '0);
    #1;
    checkOutput("mfhi_rd", 64'(mduRd), 64'h1234_5678);
    checkOutput("mfhi_stall", 64'(stallReq), 64'd0);

    // Deliberate start while busy: must be dropped, with the stall held high.
    nextCycle();
    applyStimulus(1'b1, MDU_DIV, 32'd100, 32'd7);
    nextCycle();
    applyStimulus(1'b0, MDU_NONE, '0, '0);
    nextCycle();
    applyStimulus(1'b1, MDU_MTLO, 32'h0000_AAAA, '0);
    #1;
    checkOutput("ign_stall", 64'(stallReq), 64'd1);
    nextCycle();
    applyStimulus(1'b0, MDU_NONE, '0, '0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("ign_lo", 64'(lo), 64'd14);
    checkOutput("ign_hi", 64'(hi), 64'd2);
    checkOutput("ign_count", 64'(illegalStarts), 64'd1);

    // Reset two cycles into a mult: everything clears and nothing lands later.
    nextCycle();
    applyStimulus(1'b1, MDU_MULT, 32'd5, 32'd6);
    nextCycle();
    applyStimulus(1'b0, MDU_NONE, '0, '0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstop_busy", 64'(busy), 64'd0);
    checkOutput("rstop_hi", 64'(hi), 64'd0);
    checkOutput("rstop_lo", 64'(lo), 64'd0);
    nextCycle();
    reset = 1'b0;
    repeat (8) nextCycle();
    checkOutput("rstop_late_lo", 64'(lo), 64'd0);
    checkOutput("rstop_late_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 400; i++) begin
      nextCycle();
      if (!mPending && ($urandom_range(0, 3) != 0))
        applyStimulus(1'b1, 4'($urandom_range(0, 8)), randVal(), randVal());
      else
        applyStimulus(1'b0, 4'($urandom_range(0, 8)), randVal(), randVal());
    end
    nextCycle();
    applyStimulus(1'b0, MDU_NONE, '0, '0);
    repeat (DIV_LAT + 2) @(negedge clk);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit instantiated in the Ex stage, directly upstream of the Mem stage.
- Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo against private HI/LO registers.
- Mult/div operations are multi-cycle. The unit exposes busy and a stall request to the hazard unit, which holds the D stage while any later HI/LO instruction would collide.
- The mfhi/mflo result joins the Ex-stage result mux and travels to Mem with tNew=1, like an ALU result.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (must be >=1).
- DIV_LAT, 10, busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle strobe: Ex holds a valid MDU instruction this cycle.
- mduOp  input  4  operation code from the shared package (MDU_NONE..MDU_MFLO).
- srcA  input  32  rs value, already forwarded.
- srcB  input  32  rt value, already forwarded.
- busy  output  1  high while a mult/div is in flight.
- stallReq  output  1  busy OR (start AND mduOp is mult/multu/div/divu); goes to the hazard unit.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- mduRd  output  32  hi when mduOp==MDU_MFHI, lo when MDU_MFLO, else 0; combinational.

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, counter=0, shadow registers=0. A reset mid-operation aborts the operation; HI/LO are not updated.
- Accept rule: start is honoured only when busy==0. A start while busy is ignored; the hazard unit must never allow it, and the bench asserts this.
- Mult/div accepted at edge E0:
  - Compute the result from srcA/srcB and latch it into shadow HI/LO.
  - Load the counter with MULT_LAT or DIV_LAT and set busy=1.
  - At each subsequent edge, counter decrements.
  - At the edge where counter goes 1 to 0: busy=0, and hi/lo take the shadow values on that same edge.
  - Result: busy is high for exactly LAT cycles after E0, and the new HI/LO are visible in the first cycle with busy=0.
- mult: signed 64-bit product of srcA and srcB; hi=[63:32], lo=[31:0].
- multu: unsigned 64-bit product; hi=[63:32], lo=[31:0].
- div: lo=signed quotient truncated toward zero; hi=remainder, sign of dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient into lo, unsigned remainder into hi.
- Divide by zero (div or divu): lo=0xFFFFFFFF, hi=srcA. This is deterministic; busy behaves normally.
- mthi / mtlo when busy==0: hi (or lo) takes srcA at the next edge; single cycle, busy stays 0.
- mfhi / mflo: purely combinational read of the current hi/lo; no state change.
- While busy, hi/lo outputs keep their old values. The hazard unit stalls any mf/mt/mult/div in D, so no stale read escapes.
- MDU_NONE or start=0: no state change.
- Latency summary: mult/div → LAT+1 cycles from accept until a dependent mfhi/mflo can read. mthi/mtlo → 1 cycle. mf → 0 cycles.

Decomposition:
- Shared package mdu_pkg holds:
  - op localparams: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MFHI=7, MDU_MFLO=8.
  - helper predicate is_mdu_busy_op for mult/multu/div/divu.
  - default latencies.
- One sub-module, mdu_calc: combinational 64-bit product and quotient/remainder with the signed, zero-divisor and overflow rules above, returning {hiNext, loNext}.
- Top module mdu holds the counter, shadow registers, HI/LO, busy/stallReq and the output mux.

Test Plan:
- Reset during op: mult accepted, reset pulsed at cycle 2 → busy=0 immediately, hi=lo=0, no later update.
- mult: srcA=0xFFFFFFFE (-2), srcB=3, MULT_LAT=5 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu → hi=0x00000002, lo=0xFFFFFFFA.
- div: srcA=0xFFFFFFF9 (-7), srcB=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. divu 7/0 → lo=0xFFFFFFFF, hi=7.
- Overflow div: 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0; mflo on the first non-busy cycle returns mduRd=0x80000000.
- Write/read: mthi srcA=0x12345678 → hi=0x12345678 next cycle, busy never asserts. Then mfhi → mduRd=0x12345678 combinationally. stallReq=0 throughout.
- Ignored start: div accepted, mtlo (srcA=0xAAAA) strobed while busy → lo unchanged, assertion flags it, stallReq stays 1 until completion.
